// File: rtl/vga_timing_pattern_gen.sv
// Parametrised VGA sync/timing generator with built-in test patterns.
// All outputs are registered and present the decode of (h,v) one enabled edge later.
module vga_timing_pattern_gen #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter int unsigned HSYNC_POL = 0,
  parameter int unsigned VSYNC_POL = 0,
  parameter int unsigned CBITS     = 2,
  parameter int unsigned CHK_LOG2  = 4,
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int unsigned XW       = $clog2(H_TOTAL),
  localparam int unsigned YW       = $clog2(V_TOTAL),
  localparam int unsigned CW       = 3 * CBITS
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic [1:0]    mode,
  input  logic [CW-1:0] solid_color,
  output logic          hsync,
  output logic          vsync,
  output logic          active,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          line_start,
  output logic          frame_start,
  output logic [CW-1:0] rgb
);

  localparam int unsigned BAR_W  = H_ACTIVE / 8;
  localparam int unsigned BW     = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam int unsigned HS_BEG = H_ACTIVE + H_FP;
  localparam int unsigned HS_END = HS_BEG + H_SYNC;
  localparam int unsigned VS_BEG = V_ACTIVE + V_FP;
  localparam int unsigned VS_END = VS_BEG + V_SYNC;
  localparam logic        HS_ON  = 1'(HSYNC_POL);
  localparam logic        VS_ON  = 1'(VSYNC_POL);

  logic [XW-1:0] h;
  logic [YW-1:0] v;
  logic [BW-1:0] bar_sub;
  logic [2:0]    bar_idx;
  logic [CW-1:0] frame_cnt;
  logic [1:0]    mode_q;
  logic [CW-1:0] color_q;

  logic          h_last_c;
  logic          v_last_c;
  logic          origin_c;
  logic          act_c;
  logic          hs_c;
  logic          vs_c;
  logic          chk_c;
  logic [1:0]    mode_c;
  logic [CW-1:0] color_c;
  logic [CW-1:0] bar_rgb_c;
  logic [CW-1:0] pat_c;

  // Decode of the current counter position and pattern selection
  always_comb begin
    h_last_c  = (32'(h) == H_TOTAL - 1);
    v_last_c  = (32'(v) == V_TOTAL - 1);
    origin_c  = (h == '0) && (v == '0);
    act_c     = (32'(h) < H_ACTIVE) && (32'(v) < V_ACTIVE);
    hs_c      = (32'(h) >= HS_BEG) && (32'(h) < HS_END);
    vs_c      = (32'(v) >= VS_BEG) && (32'(v) < VS_END);
    chk_c     = h[CHK_LOG2] ^ v[CHK_LOG2];
    // The pixel at (0,0) already uses the selection captured on this edge
    mode_c    = origin_c ? mode : mode_q;
    color_c   = origin_c ? solid_color : color_q;
    bar_rgb_c = {{CBITS{~bar_idx[1]}}, {CBITS{~bar_idx[2]}}, {CBITS{~bar_idx[0]}}};
    case (mode_c)
      2'd0:    pat_c = color_c;
      2'd1:    pat_c = bar_rgb_c;
      2'd2:    pat_c = {CW{chk_c}};
      default: pat_c = frame_cnt;
    endcase
    if (!act_c) begin
      pat_c = '0;
    end
  end

  // Position counters, bar counter, frame counter and per-frame pattern latch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h         <= '0;
      v         <= '0;
      bar_sub   <= '0;
      bar_idx   <= '0;
      frame_cnt <= '0;
      mode_q    <= '0;
      color_q   <= '0;
    end else if (enable) begin
      if (h_last_c) begin
        h       <= '0;
        bar_sub <= '0;
        bar_idx <= '0;
        if (v_last_c) begin
          v         <= '0;
          frame_cnt <= frame_cnt + 1'b1;
        end else begin
          v <= v + 1'b1;
        end
      end else begin
        h <= h + 1'b1;
        if (32'(bar_sub) == BAR_W - 1) begin
          bar_sub <= '0;
          bar_idx <= bar_idx + 1'b1;
        end else begin
          bar_sub <= bar_sub + 1'b1;
        end
      end
      if (origin_c) begin
        mode_q  <= mode;
        color_q <= solid_color;
      end
    end
  end

  // Output registers: all outputs move together on the same enabled edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync       <= ~HS_ON;
      vsync       <= ~VS_ON;
      active      <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      rgb         <= '0;
    end else if (enable) begin
      hsync       <= hs_c ? HS_ON : ~HS_ON;
      vsync       <= vs_c ? VS_ON : ~VS_ON;
      active      <= act_c;
      x           <= h;
      y           <= v;
      line_start  <= (h == '0);
      frame_start <= origin_c;
      rgb         <= pat_c;
    end
  end

endmodule

// File: tb/tb_vga_timing_pattern_gen.sv
// Randomised bench for vga_timing_pattern_gen against a frame-position reference model.
module tb_vga_timing_pattern_gen;

  localparam int unsigned H_ACTIVE = 16, H_FP = 2, H_SYNC = 3, H_BP = 3;
  localparam int unsigned V_ACTIVE = 8,  V_FP = 1, V_SYNC = 2, V_BP = 1;
  localparam int unsigned CBITS = 2, CHK_LOG2 = 1;
  localparam int unsigned HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned XW = $clog2(HT);
  localparam int unsigned YW = $clog2(VT);
  localparam int unsigned CW = 3 * CBITS;
  localparam int unsigned FRAME = HT * VT;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [1:0]    mode;
  logic [CW-1:0] solid_color;
  logic          hsync, vsync, active, line_start, frame_start;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [CW-1:0] rgb;

  vga_timing_pattern_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HSYNC_POL(0), .VSYNC_POL(0), .CBITS(CBITS), .CHK_LOG2(CHK_LOG2)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode),
    .solid_color(solid_color), .hsync(hsync), .vsync(vsync),
    .active(active), .x(x), .y(y), .line_start(line_start),
    .frame_start(frame_start), .rgb(rgb)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: position in frame, frame number, and per-frame latched selection
  int          p;
  int          frame_n;
  logic [1:0]  lm;
  logic [CW-1:0] lc;
  logic          e_hs, e_vs, e_act, e_ls, e_fs;
  int            e_x, e_y;
  logic [CW-1:0] e_rgb;
  // Named bar colours in display order: white, yellow, cyan, green, magenta, red, blue, black
  logic [CW-1:0] bar_tab [8] = '{6'b111111, 6'b111100, 6'b001111, 6'b001100,
                                 6'b110011, 6'b110000, 6'b000011, 6'b000000};

  // Geometry statistics
  int edge_n = 0;
  int last_fs = 0;
  bit have_fs = 0;
  int vs_low = 0;
  int act_cnt = 0;

  task automatic model_reset();
    p = 0; frame_n = 0; lm = 2'd0; lc = '0;
    e_hs = 1'b1; e_vs = 1'b1; e_act = 1'b0; e_ls = 1'b0; e_fs = 1'b0;
    e_x = 0; e_y = 0; e_rgb = '0;
    have_fs = 0;
  endtask

  task automatic model_advance();
    int hh;
    int vv;
    hh = p % HT;
    vv = p / HT;
    if (p == 0) begin
      lm = mode;
      lc = solid_color;
    end
    e_x   = hh;
    e_y   = vv;
    e_act = (hh < H_ACTIVE) && (vv < V_ACTIVE);
    e_hs  = !((hh >= H_ACTIVE + H_FP) && (hh < H_ACTIVE + H_FP + H_SYNC));
    e_vs  = !((vv >= V_ACTIVE + V_FP) && (vv < V_ACTIVE + V_FP + V_SYNC));
    e_ls  = (hh == 0);
    e_fs  = (p == 0);
    if (!e_act) e_rgb = '0;
    else begin
      case (lm)
        2'd0: e_rgb = lc;
        2'd1: e_rgb = bar_tab[hh / (H_ACTIVE / 8)];
        2'd2: e_rgb = ((((hh >> CHK_LOG2) ^ (vv >> CHK_LOG2)) & 1) != 0) ? '1 : '0;
        default: e_rgb = CW'(frame_n % (1 << CW));
      endcase
    end
    p++;
    if (p == int'(FRAME)) begin
      p = 0;
      frame_n++;
    end
  endtask

  task automatic check_outputs();
    check("ctl", {27'd0, hsync, vsync, active, line_start, frame_start},
          {27'd0, e_hs, e_vs, e_act, e_ls, e_fs});
    check("x", 32'(x), 32'(e_x));
    check("y", 32'(y), 32'(e_y));
    check("rgb", 32'(rgb), 32'(e_rgb));
  endtask

  // One clock: apply enable, advance the model on enabled edges, sample 1 time unit later
  task automatic step(input logic en);
    enable = en;
    @(posedge clk);
    if (en) model_advance();
    #1;
    check_outputs();
    if (en) begin
      if (!vsync) vs_low++;
      if (active) act_cnt++;
      if (frame_start) begin
        if (have_fs) check("fs_period", 32'(edge_n - last_fs), 32'(FRAME));
        last_fs = edge_n;
        have_fs = 1;
      end
      edge_n++;
    end
  endtask

  initial begin
    int guard;
    reset = 1'b1; enable = 1'b0; mode = 2'd0; solid_color = '0;
    model_reset();
    #12;
    check_outputs();
    @(negedge clk);
    reset = 1'b0;

    // Frame 0: colour bars and sync geometry
    mode = 2'd1;
    vs_low = 0; act_cnt = 0;
    for (int i = 0; i < int'(FRAME); i++) step(1'b1);
    check("vs_low_edges", 32'(vs_low), 32'd48);
    check("active_edges", 32'(act_cnt), 32'd128);

    // Frame 1: solid colour, switched to checkerboard mid-frame at y=3
    mode = 2'd0; solid_color = 6'b110000;
    for (int i = 0; i < 3 * int'(HT); i++) step(1'b1);
    mode = 2'd2;
    for (int i = 3 * int'(HT); i < int'(FRAME); i++) step(1'b1);
    // Frame 2: checkerboard takes effect
    for (int i = 0; i < int'(FRAME); i++) step(1'b1);

    // Enable gating 1,0,0,1
    step(1'b1); step(1'b0); step(1'b0); step(1'b1);

    // Random enable and selection; frame-count colour forced around the counter wrap
    guard = 0;
    while (frame_n < 70 && guard < 60000) begin
      if ($urandom_range(0, 31) == 0) begin
        mode = 2'($urandom_range(0, 3));
        solid_color = CW'($urandom);
      end
      if (frame_n >= 60) mode = 2'd3;
      step(($urandom_range(0, 4) != 0) ? 1'b1 : 1'b0);
      guard++;
    end
    check("random_frames_done", 32'(frame_n >= 70), 32'd1);

    // Asynchronous reset at (7,4)
    guard = 0;
    while (!(e_x == 7 && e_y == 4) && guard < 2 * int'(FRAME)) begin
      step(1'b1);
      guard++;
    end
    check("reached_7_4", {30'd0, 2'(x == 7 && y == 4)}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    reset = 1'b0;
    mode = 2'd1;
    step(1'b1);
    check("rst_first_fs", {31'd0, frame_start}, 32'd1);
    for (int i = 0; i < int'(FRAME) + 30; i++) step(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
